// File: rtl/alu_pkg.sv
// Shared types and constants for the tinyalu operand/result datapath.
package alu_pkg;

    localparam int unsigned OPERAND_W           = 8;
    localparam int unsigned MUL_LATENCY_DEFAULT = 3;

    typedef logic [OPERAND_W-1:0]   operand_t;
    typedef logic [2*OPERAND_W-1:0] result_t;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpAdd = 3'd1,
        OpAnd = 3'd2,
        OpXor = 3'd3,
        OpMul = 3'd4,
        OpSub = 3'd5,
        OpNot = 3'd6,
        OpInc = 3'd7
    } opcode_t;

endpackage

// File: rtl/tinyalu_if.sv
// start/done operand interface between the tinyalu driver (master) and core (slave).
// Optional busy status is present when TINYALU_BUSY_EN is defined.
interface tinyalu_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    opcode_t             opcode;
    logic                start;
    logic                done;
    logic [2*DATA_W-1:0] result;
`ifdef TINYALU_BUSY_EN
    logic                busy;

    modport master (output A, B, opcode, start, input done, result, busy);
    modport slave  (input A, B, opcode, start, output done, result, busy);
`else
    modport master (output A, B, opcode, start, input done, result);
    modport slave  (input A, B, opcode, start, output done, result);
`endif
endinterface

// File: rtl/tinyalu_mul.sv
// Fixed-latency multiplier: the product and a valid bit travel through LATENCY register stages.
module tinyalu_mul #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                valid_out,
    output logic [2*DATA_W-1:0] product
);
    logic [LATENCY-1:0]  vld_q;
    logic [2*DATA_W-1:0] prod_q [LATENCY];
    logic [2*DATA_W-1:0] prod_in;

    assign prod_in = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) prod_q[i] <= '0;
        end else begin
            vld_q[0]  <= valid_in;
            prod_q[0] <= prod_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[LATENCY-1];
    assign product   = prod_q[LATENCY-1];
endmodule

// File: rtl/tinyalu_core.sv
// tinyalu responder: accepts one operation per start request and answers with a one-cycle done.
// Define TINYALU_BUSY_EN to add the busy status output on the interface.
module tinyalu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input logic      clk,
    input logic      reset,
    tinyalu_if.slave bus
);
    localparam int unsigned RW = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StExec, StMult, StHold} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, b_q;
    opcode_t           op_q;
    logic [RW-1:0]     result_q;
    logic [RW-1:0]     alu_res;
    logic [RW-1:0]     mul_prod;
    logic [RW-1:0]     a_ext, b_ext;
    logic              accept;
    logic              mul_fire;
    logic              mul_vld;
    logic              done;

    assign accept   = (state_q == StIdle) && bus.start;
    assign mul_fire = (state_q == StMult) && (cnt_q == 3'd0);
    assign done     = (state_q == StExec) || mul_fire;

    tinyalu_mul #(
        .DATA_W  (DATA_W),
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (accept && (bus.opcode == OpMul)),
        .a         (bus.A),
        .b         (bus.B),
        .valid_out (mul_vld),
        .product   (mul_prod)
    );

    assign a_ext = {{DATA_W{1'b0}}, a_q};
    assign b_ext = {{DATA_W{1'b0}}, b_q};

    always_comb begin
        alu_res = '0;
        case (op_q)
            OpNop:   alu_res = '0;
            OpAdd:   alu_res = a_ext + b_ext;
            OpAnd:   alu_res = a_ext & b_ext;
            OpXor:   alu_res = a_ext ^ b_ext;
            OpMul:   alu_res = mul_prod;
            OpSub:   alu_res = a_ext - b_ext;
            OpNot:   alu_res = ~a_ext;
            OpInc:   alu_res = a_ext + b_ext + RW'(1);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.opcode == OpMul) begin
                        state_d = StMult;
                        cnt_d   = 3'(MUL_LATENCY - 1);
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: state_d = StHold;
            StMult: begin
                if (cnt_q == 3'd0) state_d = StHold;
                else               cnt_d   = cnt_q - 3'd1;
            end
            StHold: begin
                // Initiator keeps start high until it sees done; wait for it to let go.
                if (!bus.start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OpNop;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.opcode;
            end
            if (done) result_q <= alu_res;
        end
    end

    assign bus.done   = done;
    assign bus.result = done ? alu_res : result_q;
`ifdef TINYALU_BUSY_EN
    assign bus.busy   = (state_q == StExec) || (state_q == StMult);
`endif
endmodule

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
- Responder end of the tinyalu start/done operand interface. Captures A, B and opcode on start and computes one of 8 operations.
- Returns the result with a single-cycle done pulse.
- Single-cycle ops finish 1 cycle after acceptance; MUL goes through a fixed-latency pipeline.
- Sits under the ALU top, driven by the tinyalu bench/driver.

Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W.
- MUL_LATENCY, 3, cycles from acceptance to done for MUL; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  DATA_W  operand A (operand_t).
- B  input  DATA_W  operand B (operand_t).
- opcode  input  3  operation (opcode_t).
- start  input  1  request; initiator holds it high until done is seen.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  2*DATA_W  result (result_t).

Behaviour:
- Reset, asserted at any time, takes effect immediately:
  - state = IDLE, done = 0, result = 0, captured operands = 0.
  - MUL pipeline valid bits cleared; any in-flight operation is discarded with no done.
- States:
  - IDLE: when start=1 at a rising edge, capture A, B and opcode.
    - Non-MUL opcode -> EXEC.
    - MUL -> MULT, with counter loaded to MUL_LATENCY-1.
  - EXEC: one cycle. Drive done=1 and update result. Go to HOLD.
  - MULT: decrement counter each cycle. When counter = 0, drive done=1, result = product, go to HOLD.
    - MUL_LATENCY=1 behaves like EXEC.
  - HOLD: wait until start=0, then go to IDLE. done=0 throughout.
- Handshake rules:
  - start held high after done never re-triggers an operation.
  - Changes on A, B or opcode after acceptance are ignored until the next acceptance.
  - done is never high for two consecutive cycles.
- result holds its last value between done pulses and is only updated when done is asserted.
- Arithmetic: operands are zero-extended to 2*DATA_W and wrap mod 2^(2*DATA_W).
  - NOP=0: result = 0, done still pulses.
  - ADD=1: A+B.
  - AND=2: A&B.
  - XOR=3: A^B.
  - MUL=4: A*B.
  - SUB=5: A-B, two's complement; e.g. 3-5 = 16'hFFFE.
  - NOT=6: bitwise invert of zero-extended A, i.e. {all 1s, ~A}.
  - INC=7: A+B+1.
- Latency from the accepting edge to done:
  - MUL: MUL_LATENCY cycles.
  - All other opcodes: 1 cycle.
- Back-to-back: the earliest next acceptance is 1 cycle after start falls while in HOLD. Minimum throughput is 3 cycles per op.

Optional Feature:
- Macro: TINYALU_BUSY_EN.
- Defined:
  - Adds output port busy (1 bit), reset 0.
  - busy is high from the cycle after acceptance through the done cycle inclusive; low in IDLE and HOLD.
- Undefined:
  - Port absent; behaviour otherwise identical.

Decomposition:
- alu_pkg holds:
  - operand_t (DATA_W bits) and result_t (2*DATA_W bits).
  - opcode_t enum with encodings NOP..INC as above.
  - Constant MUL_LATENCY_DEFAULT = 3.
- One sub-module, tinyalu_mul:
  - Pipelined multiplier carrying a valid bit through MUL_LATENCY stages.
  - Valid bits cleared by reset.
  - The core's counter and the pipeline valid-out must agree; the bench asserts this.

Test Plan:
- Reset, then A=8'd200, B=8'd100, ADD -> done exactly 1 cycle after acceptance, result = 16'd300.
- A=8'd255, B=8'd255, MUL -> done exactly 3 cycles after acceptance, result = 16'hFE01; no done at cycles 1-2.
- SUB A=3, B=5 -> 16'hFFFE. NOT A=8'h0F -> 16'hFFF0. INC A=255, B=255 -> 16'd511. NOP -> result 0 with done pulse.
- Hold start high 10 cycles after done -> exactly one done pulse. Drop start, reissue XOR A=8'hAA, B=8'hFF -> 16'h0055.
- MUL in flight, assert reset 1 cycle after acceptance -> done never pulses, result = 0. After release, AND A=8'hF0, B=8'h3C -> 16'h0030.
- With TINYALU_BUSY_EN, MUL -> busy high exactly 3 cycles, ending with the done cycle. Build without the macro and confirm compile with no busy port.
